inv_shift_row_stream: RTL and testbench

INV_SHIFT_ROW_STREAM -- requirements
Module: inv_shift_row_stream

---
 rtl/inv_shift_row_stream.sv | 87 ++++++++
 tb/tb_inv_shift_row_stream.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_row_stream.sv
// Streaming AES InvShiftRows: 16-byte blocks in column-major order, ping-pong
// buffered so one block can fill while the other drains.
module inv_shift_row_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       ovf_err
);

    logic [7:0] bank [2][16];
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wb;
    logic       rb;
    logic [3:0] wi;
    logic [3:0] ri;
    logic       in_fire;
    logic       out_fire;
    logic [1:0] src_col;
    logic [3:0] src_idx;

    assign in_ready  = !full[wb];
    assign out_valid = full[rb];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Row r of the output is row r of the stored block rotated right by r,
    // so output column c reads stored column (c - r) mod 4.
    assign src_col  = ri[3:2] - ri[1:0];
    assign src_idx  = {src_col, ri[1:0]};
    assign out_data = bank[rb][src_idx];
    assign out_last = out_valid && (ri == 4'd15);

    // Fill and drain always target different banks, so both updates can land
    // on the same edge without conflict.
    always_comb begin
        full_nxt = full;
        if (in_fire && (wi == 4'd15)) begin
            full_nxt[wb] = 1'b1;
        end
        if (out_fire && (ri == 4'd15)) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb      <= 1'b0;
            rb      <= 1'b0;
            wi      <= 4'd0;
            ri      <= 4'd0;
            full    <= 2'b00;
            ovf_err <= 1'b0;
        end else begin
            full <= full_nxt;
            if (in_fire) begin
                wi <= wi + 4'd1;
                if (wi == 4'd15) begin
                    wb <= ~wb;
                end
            end
            if (out_fire) begin
                ri <= ri + 4'd1;
                if (ri == 4'd15) begin
                    rb <= ~rb;
                end
            end
            if (in_valid && !in_ready) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            bank[wb][wi] <= in_data;
        end
    end

endmodule

// File: tb/tb_inv_shift_row_stream.sv
// Directed bench for inv_shift_row_stream: a block-level queue model checked
// every cycle, plus literal expected sequences for the reference vectors.
module tb_inv_shift_row_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       ovf_err;

    inv_shift_row_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp030 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    logic [7:0] fwd031 [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

    // Model: whole blocks are held until complete, then their output order is
    // produced from the row/column rule and queued.
    logic [7:0] in_buf [$];
    logic [7:0] exp_q [$];
    int         pending = 0;
    int         out_pos = 0;
    logic       ovf_m = 1'b0;
    bit         live = 1'b0;
    int         cyc = 0;
    int         in_stamp [$];
    int         out_stamp [$];
    logic [7:0] out_log [$];
    logic [7:0] last_byte;
    bit         stalled = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (rst) begin
            in_buf.delete();
            exp_q.delete();
            pending = 0;
            out_pos = 0;
            ovf_m   = 1'b0;
            live    = 1'b1;
        end else if (live) begin
            acc = in_valid && (pending < 2);
            if (in_valid && pending >= 2) ovf_m = 1'b1;
            if (pending > 0 && out_ready) begin
                void'(exp_q.pop_front());
                out_pos++;
                if (out_pos == 16) begin
                    out_pos = 0;
                    pending--;
                end
            end
            if (acc) begin
                in_buf.push_back(in_data);
                in_stamp.push_back(cyc);
                if (in_buf.size() == 16) begin
                    for (int i = 0; i < 16; i++) begin
                        int r, c;
                        r = i % 4;
                        c = i / 4;
                        exp_q.push_back(in_buf[4 * ((c - r + 4) % 4) + r]);
                    end
                    pending++;
                    in_buf.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("in_ready", in_ready, pending < 2);
            check("out_valid", out_valid, pending > 0);
            check("ovf_err", ovf_err, ovf_m);
            check("out_last", out_last, (pending > 0) && (out_pos == 15));
            if (pending > 0) check("out_data", out_data, exp_q[0]);
            if (stalled) begin
                check("stall_data", out_data, stall_data);
                check("stall_last", out_last, stall_last);
            end
            stalled    = out_valid && !out_ready && !rst;
            stall_data = out_data;
            stall_last = out_last;
            if (out_valid && out_ready && !rst) begin
                out_log.push_back(out_data);
                out_stamp.push_back(cyc + 1);
                if (out_last) last_byte = out_data;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        out_log.delete();
        out_stamp.delete();
        in_stamp.delete();
    endtask

    task automatic drain();
        int n = 0;
        while (pending > 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", pending, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ovf", ovf_err, 0);

        // Reference vector 00..0F with latency check
        out_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 16; i++) send(8'(i));
        check("latency_valid", out_valid, 1);
        drain();
        check("ref_count", out_log.size(), 16);
        for (int i = 0; i < 16 && i < out_log.size(); i++) check("ref_byte", out_log[i], exp030[i]);
        check("ref_last_byte", last_byte, 8'h03);
        if (out_stamp.size() > 0 && in_stamp.size() >= 16)
            check("ref_latency", out_stamp[0], in_stamp[15] + 1);

        // Round trip of forward ShiftRows
        clear_logs();
        for (int i = 0; i < 16; i++) send(fwd031[i]);
        drain();
        check("rt_count", out_log.size(), 16);
        for (int i = 0; i < 16 && i < out_log.size(); i++) check("rt_byte", out_log[i], 8'(i));

        // Three blocks offered with output stalled
        out_ready = 1'b0;
        clear_logs();
        for (int b = 0; b < 3; b++) begin
            logic [7:0] base;
            base = (b == 0) ? 8'h10 : (b == 1) ? 8'h50 : 8'h70;
            for (int j = 0; j < 16; j++) send(base + 8'(j));
        end
        check("ovf_in_ready", in_ready, 0);
        check("ovf_flag", ovf_err, 1);
        check("ovf_out_valid", out_valid, 1);
        out_ready = 1'b1;
        n = 0;
        while (!(out_last && out_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ovf_first_last_seen", out_last, 1);
        @(posedge clk);
        #1;
        check("ovf_ready_after_free", in_ready, 1);
        drain();
        check("ovf_count", out_log.size(), 32);
        for (int i = 0; i < 32 && i < out_log.size(); i++)
            check("ovf_byte", out_log[i], ((i < 16) ? 8'h10 : 8'h50) | exp030[i % 16]);
        check("ovf_sticky", ovf_err, 1);
        pulse_reset();
        check("ovf_cleared", ovf_err, 0);

        // Continuous streaming of 4 blocks
        out_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 64; i++) send(8'(i));
        drain();
        check("stream_count", out_log.size(), 64);
        if (out_stamp.size() == 64 && in_stamp.size() == 64) begin
            check("stream_in_gapless", in_stamp[63] - in_stamp[0], 63);
            check("stream_out_gapless", out_stamp[63] - out_stamp[0], 63);
            check("stream_latency", out_stamp[0], in_stamp[15] + 1);
        end
        for (int i = 0; i < 64 && i < out_log.size(); i++)
            check("stream_byte", out_log[i], 8'(i & 8'hF0) | exp030[i % 16]);

        // Reset mid-block discards the partial block
        for (int i = 0; i < 7; i++) send(8'hA0 + 8'(i));
        pulse_reset();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        clear_logs();
        for (int i = 0; i < 16; i++) send(8'(i));
        drain();
        check("midrst_count", out_log.size(), 16);
        for (int i = 0; i < 16 && i < out_log.size(); i++) check("midrst_byte", out_log[i], exp030[i]);

        // Random backpressure; ordering and stability checked by the monitor
        clear_logs();
        fork
            begin
                for (int i = 0; i < 32; i++) send(8'($urandom));
            end
            begin
                repeat (120) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", out_log.size(), 32);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
